// File: rtl/vinst_fetch_pkg.sv
// Shared types for the instruction fetch front end: the instruction word
// and the run/drain state encoding.
package vinst_fetch_pkg;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [23:0] operand;
  } sa_inst_t;

  typedef enum logic [1:0] {
    VF_IDLE  = 2'd0,
    VF_RUN   = 2'd1,
    VF_DRAIN = 2'd2
  } vf_state_t;

endpackage

// File: rtl/vinst_fetch_sync_fifo.sv
// Count-based synchronous FIFO. Exposes next-cycle head and count so the
// owner can register its valid/data outputs without an extra cycle of latency.
module sync_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic [31:0]
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  T                       wr_data,
  input  logic                   rd_en,
  input  logic                   flush,
  output T                       head_next_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [$clog2(DEPTH):0] count_next_o
);

  localparam int PW = $clog2(DEPTH);

  T               mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW:0]    count_q, count_d;
  logic           do_wr, do_rd;

  assign do_wr = wr_en && !flush;
  assign do_rd = rd_en && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{PW{1'b0}}, do_wr} - {{PW{1'b0}}, do_rd};
    end
  end

  // A write lands on the next head slot only when the queue is (or becomes) empty.
  always_comb begin
    head_next_o = mem_q[rd_ptr_d];
    if (do_wr && (wr_ptr_q == rd_ptr_d)) head_next_o = wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/vinst_fetch.sv
// Instruction producer for vinst_ctl: buffers loader words and issues them
// over inst/iavail/ird under an IDLE/RUN/DRAIN controller.
module vinst_fetch
  import vinst_fetch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_valid,
  input  sa_inst_t               wr_inst,
  output logic                   wr_ready,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   flush,
  output sa_inst_t               inst,
  output logic                   iavail,
  input  logic                   ird,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       issued,
  output logic                   busy,
  output logic                   done,
  output vf_state_t              dbg_state
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_CNT = LW'(DEPTH);

  // Handshakes: a word moves loader->FIFO when wr_valid && wr_ready, and
  // FIFO->vinst_ctl when iavail && ird; both outputs are registered and
  // inst holds while iavail && !ird. flush cancels both moves.
  vf_state_t        state_q, state_d;
  logic             iavail_q, iavail_d;
  sa_inst_t         inst_q, inst_d;
  logic             wr_ready_q, wr_ready_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic             done_q, done_d;
  logic             push, pop;
  sa_inst_t         head_next;
  logic [LW-1:0]    count, count_next;

  assign push = wr_valid && wr_ready_q && !flush;
  assign pop  = iavail_q && ird && !flush;

  sync_fifo #(
    .DEPTH (DEPTH),
    .T     (sa_inst_t)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (push),
    .wr_data      (wr_inst),
    .rd_en        (pop),
    .flush        (flush),
    .head_next_o  (head_next),
    .count_o      (count),
    .count_next_o (count_next)
  );

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    issued_d = issued_q;
    if (pop && (issued_q != '1)) issued_d = issued_q + 1'b1;
    case (state_q)
      VF_IDLE: begin
        if (start) begin
          state_d  = VF_RUN;
          issued_d = '0;
        end
      end
      VF_RUN: begin
        if (stop) state_d = VF_DRAIN;
      end
      VF_DRAIN: begin
        if (count_next == '0) begin
          state_d = VF_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = VF_IDLE;
    endcase
    iavail_d   = (state_d != VF_IDLE) && (count_next != '0);
    inst_d     = iavail_d ? head_next : inst_q;
    wr_ready_d = (count_next != FULL_CNT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= VF_IDLE;
      iavail_q   <= 1'b0;
      inst_q     <= '0;
      wr_ready_q <= 1'b0;
      issued_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      iavail_q   <= iavail_d;
      inst_q     <= inst_d;
      wr_ready_q <= wr_ready_d;
      issued_q   <= issued_d;
      done_q     <= done_d;
    end
  end

  assign wr_ready  = wr_ready_q;
  assign inst      = inst_q;
  assign iavail    = iavail_q;
  assign level     = count;
  assign issued    = issued_q;
  assign busy      = (state_q != VF_IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_vinst_fetch.sv
// Bench for vinst_fetch: directed scenarios then random traffic, all checked
// every cycle against a queue-based model of the fetch rules.
module tb_vinst_fetch;
  import vinst_fetch_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 32;

  logic                   clk = 1'b0;
  logic                   reset, wr_valid, start, stop, flush, ird;
  sa_inst_t               wr_inst;
  logic                   wr_ready, iavail, busy, done;
  sa_inst_t               inst;
  logic [$clog2(DEPTH):0] level;
  logic [CNT_W-1:0]       issued;
  vf_state_t              dbg_state;

  vinst_fetch #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_inst   (wr_inst),
    .wr_ready  (wr_ready),
    .start     (start),
    .stop      (stop),
    .flush     (flush),
    .inst      (inst),
    .iavail    (iavail),
    .ird       (ird),
    .level     (level),
    .issued    (issued),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0]      exp_q[$];
  vf_state_t        m_st;
  logic [CNT_W-1:0] m_issued;
  logic             m_done, m_rdy, m_avail;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    logic do_pop, do_push;
    if (reset) begin
      exp_q.delete();
      m_st     = VF_IDLE;
      m_issued = '0;
      m_done   = 1'b0;
      m_rdy    = 1'b0;
      m_avail  = 1'b0;
    end else begin
      do_pop  = m_avail && ird && !flush;
      do_push = wr_valid && m_rdy && !flush;
      m_done  = 1'b0;
      if (flush) exp_q.delete();
      else begin
        if (do_pop) begin
          void'(exp_q.pop_front());
          if (m_issued != {CNT_W{1'b1}}) m_issued = m_issued + 1;
        end
        if (do_push) exp_q.push_back(wr_inst);
      end
      case (m_st)
        VF_IDLE:  if (start) begin m_st = VF_RUN; m_issued = '0; end
        VF_RUN:   if (stop) m_st = VF_DRAIN;
        default:  if (exp_q.size() == 0) begin m_st = VF_IDLE; m_done = 1'b1; end
      endcase
      m_rdy   = (exp_q.size() != DEPTH);
      m_avail = (m_st != VF_IDLE) && (exp_q.size() > 0);
    end
  endtask

  task automatic check_outputs();
    chk("iavail",   64'(iavail),    64'(m_avail));
    chk("level",    64'(level),     64'(exp_q.size()));
    chk("wr_ready", 64'(wr_ready),  64'(m_rdy));
    chk("busy",     64'(busy),      64'(m_st != VF_IDLE));
    chk("done",     64'(done),      64'(m_done));
    chk("issued",   64'(issued),    64'(m_issued));
    chk("state",    64'(dbg_state), 64'(m_st));
    if (m_avail) chk("inst", 64'(inst), 64'(exp_q[0]));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_outputs();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic quiet();
    reset = 1'b0; wr_valid = 1'b0; start = 1'b0; stop = 1'b0; flush = 1'b0; ird = 1'b0;
    wr_inst = sa_inst_t'($urandom());
  endtask

  task automatic write_n(input int n);
    wr_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      wr_inst = sa_inst_t'($urandom());
      step();
    end
    wr_valid = 1'b0;
  endtask

  initial begin
    quiet();
    // Reset with ird/wr_valid active must leave everything at reset values
    reset = 1'b1; ird = 1'b1; wr_valid = 1'b1;
    steps(2);
    chk("reset_inst", 64'(inst), 64'd0);
    quiet();
    step();

    // Preload in IDLE, then start
    write_n(3);
    step();
    start = 1'b1; step(); start = 1'b0;

    // Back-to-back pops
    ird = 1'b1; steps(3); ird = 1'b0;
    step();

    // Fill, then pop and write together around the full boundary
    write_n(DEPTH);
    step();
    ird = 1'b1; wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_inst = sa_inst_t'($urandom());
      step();
    end
    wr_valid = 1'b0;
    steps(DEPTH + 1);
    ird = 1'b0;

    // Drain with two queued
    write_n(2);
    stop = 1'b1; step(); stop = 1'b0;
    ird = 1'b1; steps(2); ird = 1'b0;
    steps(2);

    // start and stop together in IDLE: start wins
    start = 1'b1; stop = 1'b1; step(); quiet();

    // Flush with a simultaneous write
    write_n(5);
    flush = 1'b1; wr_valid = 1'b1; wr_inst = sa_inst_t'($urandom()); step();
    quiet(); step();

    // Reset mid-RUN with entries queued
    write_n(4);
    reset = 1'b1; ird = 1'b1; step();
    chk("reset_mid_inst", 64'(inst), 64'd0);
    quiet(); step();

    // Flush while draining ends the drain
    start = 1'b1; step(); start = 1'b0;
    write_n(3);
    stop = 1'b1; step(); stop = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    steps(2);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 199) == 0);
      wr_valid = ($urandom_range(0, 1) == 1);
      wr_inst  = sa_inst_t'($urandom());
      ird      = ($urandom_range(0, 2) != 0);
      start    = ($urandom_range(0, 19) == 0);
      stop     = ($urandom_range(0, 29) == 0);
      flush    = ($urandom_range(0, 49) == 0);
      step();
    end
    quiet();
    steps(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
